alu_control_md: RTL and testbench

- Parametrised successor of the 3-bit ALU control decoder.
- Decodes ALUOp/funct into a 4-bit ALU operation covering the full MIPS R-type integer set.
- Adds a multi-cycle multiply/divide sequencer with HI/LO registers and a pipeline stall output.
- Sits in the EX stage beside the ALU. The datapath result mux uses result_sel.

---
 rtl/alu_control_md.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_control_md.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_md.sv
// EX-stage ALU control decoder with a multi-cycle multiply/divide unit.
// Ports: clk, reset, valid, ALUOp, funct, rs_val, rt_val in; operation,
//   result_sel, illegal, stall (comb) and busy, hi, lo (registered) out.
module alu_control_md #(
  parameter int WIDTH     = 32,
  parameter bit MD_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       operation,
  output logic [1:0]       result_sel,
  output logic             illegal,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] opAnd  = 4'b0000;
  localparam logic [3:0] opOr   = 4'b0001;
  localparam logic [3:0] opAdd  = 4'b0010;
  localparam logic [3:0] opXor  = 4'b0011;
  localparam logic [3:0] opSltu = 4'b0101;
  localparam logic [3:0] opSub  = 4'b0110;
  localparam logic [3:0] opSlt  = 4'b0111;
  localparam logic [3:0] opSll  = 4'b1000;
  localparam logic [3:0] opSrl  = 4'b1001;
  localparam logic [3:0] opSra  = 4'b1010;
  localparam logic [3:0] opNor  = 4'b1100;

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    sIdle,
    sIter,
    sFix
  } stateT;

  stateT           state;
  logic [CW-1:0]   cnt;
  logic            divMode;
  logic            sgnMode;
  logic            negA;
  logic            negB;
  logic [WIDTH-1:0] aRaw;
  logic [WIDTH-1:0] dMag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;

  logic [3:0] fnOp;
  logic [1:0] fnSel;
  logic       fnKnown;
  logic       fnMd;
  logic       fnHl;
  logic       fnDiv;
  logic       fnSgn;
  logic       rType;
  logic       mdOp;
  logic       hlOp;
  logic       accept;

  always_comb begin
    fnOp    = opAdd;
    fnSel   = 2'b00;
    fnKnown = 1'b1;
    fnMd    = 1'b0;
    fnHl    = 1'b0;
    fnDiv   = 1'b0;
    fnSgn   = 1'b0;
    case (funct)
      6'h20, 6'h21: fnOp = opAdd;
      6'h22, 6'h23: fnOp = opSub;
      6'h24: fnOp = opAnd;
      6'h25: fnOp = opOr;
      6'h26: fnOp = opXor;
      6'h27: fnOp = opNor;
      6'h2A: fnOp = opSlt;
      6'h2B: fnOp = opSltu;
      6'h00: fnOp = opSll;
      6'h02: fnOp = opSrl;
      6'h03: fnOp = opSra;
      6'h10: begin
        fnKnown = MD_ENABLE;
        fnHl    = MD_ENABLE;
        fnSel   = MD_ENABLE ? 2'b01 : 2'b00;
      end
      6'h12: begin
        fnKnown = MD_ENABLE;
        fnHl    = MD_ENABLE;
        fnSel   = MD_ENABLE ? 2'b10 : 2'b00;
      end
      6'h18, 6'h19, 6'h1A, 6'h1B: begin
        fnKnown = MD_ENABLE;
        fnMd    = MD_ENABLE;
        fnDiv   = funct[1];
        fnSgn   = ~funct[0];
      end
      default: fnKnown = 1'b0;
    endcase
  end

  always_comb begin
    operation = opAdd;
    unique case (1'b1)
      (ALUOp == 2'b00): operation = opAdd;
      (ALUOp == 2'b01): operation = opSub;
      (ALUOp == 2'b11): operation = opOr;
      default:          operation = fnOp;
    endcase
  end

  assign rType      = (ALUOp == 2'b10);
  assign result_sel = rType ? fnSel : 2'b00;
  assign illegal    = valid & rType & ~fnKnown;
  assign mdOp       = valid & rType & fnMd;
  assign hlOp       = valid & rType & fnHl;
  assign busy       = (state != sIdle);
  assign stall      = busy & (mdOp | hlOp);
  assign accept     = mdOp & ~busy;

  // Operand magnitudes; most-negative maps to itself, which is the
  // correct unsigned magnitude.
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;

  assign aNeg = fnSgn & rs_val[WIDTH-1];
  assign bNeg = fnSgn & rt_val[WIDTH-1];
  assign aMag = aNeg ? -rs_val : rs_val;
  assign bMag = bNeg ? -rt_val : rt_val;

  // One iteration step. Multiply shifts {rem,q} right after a
  // conditional add; divide shifts left with a restoring subtract.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] qNext;

  assign mulSum = {1'b0, rem} + (q[0] ? {1'b0, dMag} : '0);
  assign trial  = {rem, q[WIDTH-1]} - {1'b0, dMag};

  always_comb begin
    remNext = mulSum[WIDTH:1];
    qNext   = {mulSum[0], q[WIDTH-1:1]};
    if (divMode) begin
      if (!trial[WIDTH]) begin
        remNext = trial[WIDTH-1:0];
        qNext   = {q[WIDTH-2:0], 1'b1};
      end else begin
        remNext = {rem[WIDTH-2:0], q[WIDTH-1]};
        qNext   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction; a zero divisor bypasses it entirely.
  logic             negRes;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] hiFix;
  logic [WIDTH-1:0] loFix;

  assign negRes = sgnMode & (negA ^ negB);
  assign prod   = negRes ? -{rem, q} : {rem, q};

  always_comb begin
    {hiFix, loFix} = prod;
    if (divMode) begin
      if (dMag == '0) begin
        hiFix = aRaw;
        loFix = '1;
      end else begin
        hiFix = (sgnMode & negA) ? -rem : rem;
        loFix = negRes ? -q : q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= sIdle;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        sIdle: begin
          if (accept) begin
            state   <= sIter;
            cnt     <= CW'(WIDTH - 1);
            divMode <= fnDiv;
            sgnMode <= fnSgn;
            negA    <= aNeg;
            negB    <= bNeg;
            aRaw    <= rs_val;
            rem     <= '0;
            dMag    <= fnDiv ? bMag : aMag;
            q       <= fnDiv ? aMag : bMag;
          end
        end
        sIter: begin
          rem <= remNext;
          q   <= qNext;
          if (cnt == '0) state <= sFix;
          else cnt <= cnt - 1'b1;
        end
        sFix: begin
          hi    <= hiFix;
          lo    <= loFix;
          state <= sIdle;
        end
        default: state <= sIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: decode table, mult/div results,
// latency, stall hazards, reset abort and the 8-bit builds.
module tb_alu_control_md;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid;
  logic        valid8;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [5:0]  funct8;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [7:0]  rs8;
  logic [7:0]  rt8;

  logic [3:0]  op;
  logic [1:0]  sel;
  logic        ill;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [3:0]  op8;
  logic [1:0]  sel8;
  logic        ill8;
  logic        stall8;
  logic        busy8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  logic [3:0]  op8n;
  logic [1:0]  sel8n;
  logic        ill8n;
  logic        stall8n;
  logic        busy8n;
  logic [7:0]  hi8n;
  logic [7:0]  lo8n;

  alu_control_md #(.WIDTH(32), .MD_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ALUOp(ALUOp),
    .funct(funct), .rs_val(rs), .rt_val(rt), .operation(op),
    .result_sel(sel), .illegal(ill), .stall(stall), .busy(busy),
    .hi(hi), .lo(lo)
  );

  alu_control_md #(.WIDTH(8), .MD_ENABLE(1'b1)) dut8 (
    .clk(clk), .reset(reset), .valid(valid8), .ALUOp(ALUOp),
    .funct(funct8), .rs_val(rs8), .rt_val(rt8), .operation(op8),
    .result_sel(sel8), .illegal(ill8), .stall(stall8), .busy(busy8),
    .hi(hi8), .lo(lo8)
  );

  alu_control_md #(.WIDTH(8), .MD_ENABLE(1'b0)) dut8n (
    .clk(clk), .reset(reset), .valid(valid8), .ALUOp(ALUOp),
    .funct(funct8), .rs_val(rs8), .rt_val(rt8), .operation(op8n),
    .result_sel(sel8n), .illegal(ill8n), .stall(stall8n),
    .busy(busy8n), .hi(hi8n), .lo(lo8n)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {operation, result_sel, illegal} for valid=1, ALUOp=10
  function automatic logic [6:0] expDec(input logic [5:0] f);
    logic [3:0] o;
    logic [1:0] s;
    logic       i;
    o = 4'b0010;
    s = 2'b00;
    i = 1'b0;
    case (f)
      6'h20, 6'h21: o = 4'b0010;
      6'h22, 6'h23: o = 4'b0110;
      6'h24: o = 4'b0000;
      6'h25: o = 4'b0001;
      6'h26: o = 4'b0011;
      6'h27: o = 4'b1100;
      6'h2A: o = 4'b0111;
      6'h2B: o = 4'b0101;
      6'h00: o = 4'b1000;
      6'h02: o = 4'b1001;
      6'h03: o = 4'b1010;
      6'h10: s = 2'b01;
      6'h12: s = 2'b10;
      6'h18, 6'h19, 6'h1A, 6'h1B: o = 4'b0010;
      default: i = 1'b1;
    endcase
    return {o, s, i};
  endfunction

  task automatic runMd(input string tag, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    int n;
    @(negedge clk);
    valid = 1'b1; ALUOp = 2'b10; funct = f; rs = a; rt = b;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, n, 33);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sc;
    int n;
    logic anyBusy;
    logic [5:0] mdF [6];
    reset = 1'b1; valid = 1'b0; valid8 = 1'b0; ALUOp = 2'b00;
    funct = 6'h00; funct8 = 6'h00; rs = '0; rt = '0;
    rs8 = '0; rt8 = '0;
    @(negedge clk);

    // Decode sweep while reset blocks any accept
    valid = 1'b1; ALUOp = 2'b10;
    for (int f = 0; f < 64; f++) begin
      funct = 6'(f);
      #1;
      chk($sformatf("dec f=%02h", f), {op, sel, ill}, expDec(6'(f)));
    end
    funct = 6'h3F;
    ALUOp = 2'b00; #1; chk("dec aluop00", {op, sel, ill}, 7'b0010_00_0);
    ALUOp = 2'b01; #1; chk("dec aluop01", {op, sel, ill}, 7'b0110_00_0);
    ALUOp = 2'b11; #1; chk("dec aluop11", {op, sel, ill}, 7'b0001_00_0);
    ALUOp = 2'b10; valid = 1'b0; #1;
    chk("dec invalid", {op, ill}, 5'b0010_0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst stall", stall, 1'b0);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst busy8", busy8, 1'b0);

    runMd("mult", 6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runMd("multu", 6'h19, 32'hFFFFFFFD, 32'd7, 32'h6, 32'hFFFFFFEB);
    runMd("div -7/2", 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF,
          32'hFFFFFFFD);
    runMd("div 5/0", 6'h1A, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    runMd("div ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0,
          32'h80000000);

    // mult, add during busy, mflo from T+5
    @(negedge clk);
    valid = 1'b1; ALUOp = 2'b10; funct = 6'h18;
    rs = 32'hFFFFFFFD; rt = 32'd7;
    sc = 0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      valid = (c == 2) || (c >= 5);
      funct = (c == 2) ? 6'h20 : 6'h12;
      #1;
      if (c == 2) chk("add no stall", stall, 1'b0);
      if (c >= 5 && c <= 33 && stall) sc++;
      if (c == 34) begin
        chk("mflo stall drop", stall, 1'b0);
        chk("mflo sel", sel, 2'b10);
        chk("mflo lo", lo, 32'hFFFFFFEB);
      end
    end
    chk("mflo stall cycles", sc, 29);
    valid = 1'b0;

    // back-to-back divides
    @(negedge clk);
    valid = 1'b1; funct = 6'h1A; rs = 32'd100; rt = 32'd7;
    sc = 0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 1) begin
        funct = 6'h1B; rs = 32'hFFFFFF9C; rt = 32'd7;
      end
      if (c == 35) valid = 1'b0;
      #1;
      if (stall) sc++;
      if (c == 34) begin
        chk("b2b first lo", lo, 32'd14);
        chk("b2b first hi", hi, 32'd2);
        chk("b2b busy low", busy, 1'b0);
      end
      if (c == 35) chk("b2b accepted", busy, 1'b1);
    end
    chk("b2b stall cycles", sc, 33);
    n = 1;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    chk("b2b second busy cycles", n, 33);
    chk("b2b second lo", lo, 32'h24924916);
    chk("b2b second hi", hi, 32'd2);

    // reset mid-divide with an md_op present
    @(negedge clk);
    valid = 1'b1; funct = 6'h1A; rs = 32'd1234; rt = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      valid = (c == 10);
      funct = 6'h18;
      reset = (c == 10);
    end
    @(negedge clk);
    reset = 1'b0; valid = 1'b0;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst hi", hi, 32'h0);
    chk("midrst lo", lo, 32'h0);

    // reset overrides accept while idle
    @(negedge clk);
    reset = 1'b1; valid = 1'b1; funct = 6'h18; rs = 32'd3; rt = 32'd3;
    @(negedge clk);
    reset = 1'b0; valid = 1'b0;
    #1;
    chk("rst blocks accept", busy, 1'b0);
    @(negedge clk);
    chk("rst blocks accept 2", {busy, lo}, 33'h0);

    // 8-bit enabled build: multu 0xFF*0xFF
    @(negedge clk);
    valid8 = 1'b1; ALUOp = 2'b10; funct8 = 6'h19;
    rs8 = 8'hFF; rt8 = 8'hFF;
    @(negedge clk);
    valid8 = 1'b0;
    n = 0;
    while (busy8 === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("w8 busy cycles", n, 9);
    chk("w8 hi", hi8, 8'hFE);
    chk("w8 lo", lo8, 8'h01);

    // 8-bit disabled build
    mdF = '{6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};
    anyBusy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid8 = 1'b1; funct8 = mdF[i];
      #1;
      chk($sformatf("nomd ill f=%02h", mdF[i]), {ill8n, sel8n}, 3'b100);
      anyBusy = anyBusy | busy8n;
    end
    funct8 = 6'h18;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      anyBusy = anyBusy | busy8n | stall8n;
    end
    chk("nomd busy never", anyBusy, 1'b0);
    chk("nomd hilo", {hi8n, lo8n}, 16'h0);
    valid8 = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
